// File: rtl/x_mem_bridge_pkg.sv
// Shared types and constants for the x_mem_bridge core-to-RAM/peripheral bridge.
package x_mem_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_WAIT = 2'd1,
      PERIPH   = 2'd2,
      RESP     = 2'd3
   } state_t;

   localparam int PERIPH_REGION_BIT = 31;
   localparam int MAX_WAIT          = 15;

endpackage

// File: rtl/x_mem_bridge_ram.sv
// Local word RAM: synchronous write, asynchronous read, contents never reset.
module x_mem_bridge_ram #(
   parameter int WORDS = 1024,
   parameter int IDX_W = $clog2(WORDS)
) (
   input  logic             clk_sys,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk_sys) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/x_mem_bridge.sv
// Bridges a single-outstanding core request to local RAM (addr[31]=0) or a
// peripheral handshake (addr[31]=1). Optional range checking: X_MEM_BRIDGE_ERR_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for i_valid; request fields latched when sampled
// RAM_WAIT | RAM wait states, down-counter runs to terminal count 0
// PERIPH   | o_p_valid high, waiting (unbounded) for i_p_ready
// RESP     | one-cycle o_accept with o_data; RAM write happens here
module x_mem_bridge
   import x_mem_bridge_pkg::*;
#(
   parameter int RAM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_valid,
   input  logic        i_rnw,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data,
   output logic        o_accept,
   output logic [31:0] o_data,
   output logic        o_p_valid,
   output logic        o_p_rnw,
   output logic [7:0]  o_p_addr,
   output logic [31:0] o_p_data,
   input  logic        i_p_ready,
   input  logic [31:0] i_p_data,
   output logic        o_err
);

   localparam int IDX_W = $clog2(RAM_WORDS);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             rnw_q;
   logic [31:0]      addr_q;
   logic [31:0]      data_q;
   logic             err_q;

   logic [31:0]      ram_addr;
   logic [31:0]      ram_rdata;
   logic [31:0]      ram_resp;
   logic             oor;
   logic             ram_we;
   logic             unused_bits;

   // In IDLE the live address feeds the RAM so a zero-wait read can be
   // captured on the same edge that samples the request.
   assign ram_addr = (state == IDLE) ? i_addr : addr_q;

`ifdef X_MEM_BRIDGE_ERR_EN
   assign oor   = |ram_addr[30:IDX_W+2];
   assign o_err = err_q;
`else
   assign oor   = 1'b0;
   assign o_err = 1'b0;
`endif

   assign ram_resp    = oor ? 32'h0 : ram_rdata;
   assign ram_we      = (state == RESP) && !rnw_q && !addr_q[PERIPH_REGION_BIT] && !oor;
   assign unused_bits = ^{ram_addr[31:IDX_W+2], ram_addr[1:0], err_q};

   x_mem_bridge_ram #(
      .WORDS (RAM_WORDS)
   ) u_ram (
      .clk_sys (i_clk),
      .we      (ram_we),
      .idx     (ram_addr[IDX_W+1:2]),
      .wdata   (data_q),
      .rdata   (ram_rdata)
   );

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         rnw_q     <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
         o_accept  <= 1'b0;
         o_data    <= '0;
         o_p_valid <= 1'b0;
         o_p_rnw   <= 1'b0;
         o_p_addr  <= '0;
         o_p_data  <= '0;
      end else begin
         o_accept <= 1'b0;
         o_data   <= '0;
         case (state)
            IDLE: begin
               if (i_valid) begin
                  rnw_q  <= i_rnw;
                  addr_q <= i_addr;
                  data_q <= i_data;
                  if (i_addr[PERIPH_REGION_BIT]) begin
                     state     <= PERIPH;
                     o_p_valid <= 1'b1;
                     o_p_rnw   <= i_rnw;
                     o_p_addr  <= i_addr[9:2];
                     o_p_data  <= i_data;
                  end else if (WAIT_CYCLES == 0) begin
                     state    <= RESP;
                     o_accept <= 1'b1;
                     o_data   <= ram_resp;
                     err_q    <= err_q | oor;
                  end else begin
                     state    <= RAM_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end
               end
            end
            RAM_WAIT: begin
               if (wait_cnt == '0) begin
                  state    <= RESP;
                  o_accept <= 1'b1;
                  o_data   <= ram_resp;
                  err_q    <= err_q | oor;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            PERIPH: begin
               if (i_p_ready) begin
                  state     <= RESP;
                  o_p_valid <= 1'b0;
                  o_accept  <= 1'b1;
                  o_data    <= i_p_data;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_x_mem_bridge.sv
// Directed self-checking bench: dut_a uses one RAM wait state, dut_b none.
module tb_x_mem_bridge;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        valid_a = 1'b0;
   logic        valid_b = 1'b0;
   logic        rnw_in = 1'b0;
   logic [31:0] addr_in = '0;
   logic [31:0] data_in = '0;
   logic        p_ready = 1'b0;
   logic [31:0] p_data = '0;

   logic        acc_a, pv_a, prnw_a, err_a;
   logic [31:0] dat_a, pdata_a;
   logic [7:0]  paddr_a;
   logic        acc_b, pv_b, prnw_b, err_b;
   logic [31:0] dat_b, pdata_b;
   logic [7:0]  paddr_b;

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] rd;
   int          lat;
   logic [31:0] words [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

`ifdef X_MEM_BRIDGE_ERR_EN
   localparam logic        ERR_EXP  = 1'b1;
   localparam logic [31:0] W0_EXP   = 32'hCAFE_F00D;
   localparam logic [31:0] OOR_EXP  = 32'h0;
`else
   localparam logic        ERR_EXP  = 1'b0;
   localparam logic [31:0] W0_EXP   = 32'h0000_1234;
   localparam logic [31:0] OOR_EXP  = 32'h0000_1234;
`endif

   always #5 clk = ~clk;

   x_mem_bridge #(.RAM_WORDS(1024), .WAIT_CYCLES(1)) dut_a (
      .i_clk(clk), .i_nrst(nrst), .i_valid(valid_a), .i_rnw(rnw_in),
      .i_addr(addr_in), .i_data(data_in), .o_accept(acc_a), .o_data(dat_a),
      .o_p_valid(pv_a), .o_p_rnw(prnw_a), .o_p_addr(paddr_a), .o_p_data(pdata_a),
      .i_p_ready(p_ready), .i_p_data(p_data), .o_err(err_a)
   );

   x_mem_bridge #(.RAM_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
      .i_clk(clk), .i_nrst(nrst), .i_valid(valid_b), .i_rnw(rnw_in),
      .i_addr(addr_in), .i_data(data_in), .o_accept(acc_b), .o_data(dat_b),
      .o_p_valid(pv_b), .o_p_rnw(prnw_b), .o_p_addr(paddr_b), .o_p_data(pdata_b),
      .i_p_ready(1'b0), .i_p_data(32'h0), .o_err(err_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One RAM transfer. While the selected DUT is busy, a conflicting write
   // request is held on the bus; it must be ignored until the DUT is idle.
   task automatic xfer(input bit sel, input logic r, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rdat, output int l);
      @(negedge clk);
      rnw_in = r; addr_in = a; data_in = d;
      if (sel) valid_b = 1'b1; else valid_a = 1'b1;
      l = 0; rdat = '0;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (sel ? acc_b : acc_a) begin
            l = k;
            rdat = sel ? dat_b : dat_a;
            break;
         end
         rnw_in = 1'b0; addr_in = 32'h0000_0040; data_in = 32'hBAD0_BAD0;
      end
      valid_a = 1'b0; valid_b = 1'b0;
      @(negedge clk);
      chk("accept_pulse", sel ? acc_b : acc_a, 1'b0);
      chk("data_after_resp", sel ? dat_b : dat_a, 32'h0);
   endtask

   initial begin
      #2 nrst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_accept", acc_a, 1'b0);
      chk("rst_data", dat_a, 32'h0);
      chk("rst_p_valid", pv_a, 1'b0);
      chk("rst_p_addr", paddr_a, 8'h0);
      chk("rst_err", err_a, 1'b0);
      chk("rst_accept_b", acc_b, 1'b0);
      nrst = 1'b1;

      // write then read back with one wait state
      xfer(0, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, lat);
      chk("wr_latency", lat, 2);
      xfer(0, 1'b1, 32'h10, 32'h0, rd, lat);
      chk("rd_latency", lat, 2);
      chk("rd_data", rd, 32'hDEAD_BEEF);

      // zero wait states: preload, then stream reads with valid held high
      for (int i = 0; i < 3; i++) begin
         xfer(1, 1'b0, 32'(i * 4), words[i], rd, lat);
         chk("b_wr_latency", lat, 1);
      end
      @(negedge clk);
      valid_b = 1'b1; rnw_in = 1'b1; addr_in = 32'h0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("b2b_accept", acc_b, (k % 2 == 0 && k <= 4) ? 1'b1 : 1'b0);
         chk("b2b_data", dat_b, (k % 2 == 0 && k <= 4) ? words[k / 2] : 32'h0);
         if (k % 2 == 0) begin
            addr_in = 32'((k / 2 + 1) * 4);
            if (k == 4) valid_b = 1'b0;
         end
      end

      // peripheral read, ready arrives after 5 cycles of o_p_valid
      @(negedge clk);
      valid_a = 1'b1; rnw_in = 1'b1; addr_in = 32'h8000_0014; p_ready = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("p_valid_hold", pv_a, 1'b1);
         chk("p_addr", paddr_a, 8'h05);
         chk("p_rnw", prnw_a, 1'b1);
         chk("p_no_accept", acc_a, 1'b0);
         addr_in = 32'h8000_0020;
         if (k == 5) begin
            valid_a = 1'b0; p_ready = 1'b1; p_data = 32'h0000_5A5A;
         end
      end
      @(negedge clk);
      p_ready = 1'b0;
      chk("p_accept", acc_a, 1'b1);
      chk("p_rdata", dat_a, 32'h0000_5A5A);
      chk("p_valid_drop", pv_a, 1'b0);
      @(negedge clk);
      chk("p_accept_pulse", acc_a, 1'b0);

      // peripheral write with immediate ready
      valid_a = 1'b1; rnw_in = 1'b0; addr_in = 32'h8000_03FC; data_in = 32'hA5A5_0001;
      p_ready = 1'b1; p_data = 32'h0;
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      chk("pw_valid", pv_a, 1'b1);
      chk("pw_addr", paddr_a, 8'hFF);
      chk("pw_rnw", prnw_a, 1'b0);
      chk("pw_data", pdata_a, 32'hA5A5_0001);
      @(negedge clk);
      p_ready = 1'b0;
      chk("pw_accept", acc_a, 1'b1);
      chk("pw_valid_drop", pv_a, 1'b0);

      // reset in the middle of a peripheral transfer
      @(negedge clk);
      valid_a = 1'b1; rnw_in = 1'b1; addr_in = 32'h8000_0008;
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      chk("pr_valid", pv_a, 1'b1);
      #2 nrst = 1'b0;
      #1;
      chk("mid_rst_p_valid", pv_a, 1'b0);
      chk("mid_rst_p_addr", paddr_a, 8'h0);
      chk("mid_rst_accept", acc_a, 1'b0);
      p_ready = 1'b1; p_data = 32'hFFFF_FFFF;
      @(negedge clk);
      nrst = 1'b1; p_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_no_accept", acc_a, 1'b0);
         chk("post_rst_p_valid", pv_a, 1'b0);
      end
      xfer(0, 1'b1, 32'h10, 32'h0, rd, lat);
      chk("post_rst_latency", lat, 2);
      chk("ram_kept_over_rst", rd, 32'hDEAD_BEEF);

      // out-of-range write (index 1024)
      xfer(0, 1'b0, 32'h0, 32'hCAFE_F00D, rd, lat);
      chk("err_clear", err_a, 1'b0);
      xfer(0, 1'b0, 32'h1000, 32'h0000_1234, rd, lat);
      chk("oor_wr_latency", lat, 2);
      chk("err_set", err_a, ERR_EXP);
      xfer(0, 1'b1, 32'h0, 32'h0, rd, lat);
      chk("word0", rd, W0_EXP);
      xfer(0, 1'b1, 32'h1000, 32'h0, rd, lat);
      chk("oor_rd_latency", lat, 2);
      chk("oor_rdata", rd, OOR_EXP);
      xfer(0, 1'b1, 32'h10, 32'h0, rd, lat);
      chk("normal_after_oor", rd, 32'hDEAD_BEEF);
      chk("err_sticky", err_a, ERR_EXP);
      @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("err_rst", err_a, 1'b0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

endmodule
